// File: rtl/data_mem_copier.sv
// Block copier that masters the DataMemory port. Each word takes one READ cycle
// and one WRITE cycle. Every output is registered so level-write memory never sees glitches.
module data_mem_copier #(
  parameter int WORD     = 16,
  parameter int ADDRESSL = 10
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDRESSL-1:0] srcAddr,
  input  logic [ADDRESSL-1:0] dstAddr,
  input  logic [ADDRESSL:0]   count,
  output logic                busy,
  output logic                done,
  output logic [ADDRESSL:0]   wordsDone,
  output logic [ADDRESSL-1:0] address,
  output logic [WORD-1:0]     writeData,
  output logic                memRead,
  output logic                memWrite,
  input  logic [WORD-1:0]     readData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_reg;
  logic [ADDRESSL-1:0]   src_reg;
  logic [ADDRESSL-1:0]   dst_reg;
  logic [ADDRESSL:0]     count_reg;
  logic [ADDRESSL:0]     words_next;

  // wordsDone doubles as the copy index i; it is cleared on every accepted start.
  assign words_next = wordsDone + (ADDRESSL+1)'(1);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      count_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wordsDone <= '0;
      address   <= '0;
      writeData <= '0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_reg   <= srcAddr;
            dst_reg   <= dstAddr;
            count_reg <= count;
            wordsDone <= '0;
            if (count == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= READ;
              busy      <= 1'b1;
              memRead   <= 1'b1;
              address   <= srcAddr;
            end
          end
        end
        READ: begin
          memRead <= 1'b0;
          if (abort) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            // writeData is the hold register for the word just read.
            state_reg <= WRITE;
            memWrite  <= 1'b1;
            address   <= dst_reg + wordsDone[ADDRESSL-1:0];
            writeData <= readData;
          end
        end
        WRITE: begin
          memWrite  <= 1'b0;
          wordsDone <= words_next;
          if (abort || (words_next == count_reg)) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state_reg <= READ;
            memRead   <= 1'b1;
            address   <= src_reg + words_next[ADDRESSL-1:0];
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          memRead   <= 1'b0;
          memWrite  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_copier.sv
// Scoreboard bench for data_mem_copier: the drivers queue the expected writes and done pulses.
// A negedge monitor pops these entries and compares them with each memory write and done pulse.
module tb_data_mem_copier;
  localparam int WORD  = 16;
  localparam int AL    = 10;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstN, start, abort;
  logic [AL-1:0]   srcAddr, dstAddr;
  logic [AL:0]     count;
  logic            busy, done, memRead, memWrite;
  logic [AL:0]     wordsDone;
  logic [AL-1:0]   address;
  logic [WORD-1:0] writeData, readData;

  data_mem_copier #(.WORD(WORD), .ADDRESSL(AL)) dut (
    .clk(clk), .rstN(rstN), .start(start), .abort(abort),
    .srcAddr(srcAddr), .dstAddr(dstAddr), .count(count),
    .busy(busy), .done(done), .wordsDone(wordsDone),
    .address(address), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .readData(readData)
  );

  // DataMemory model: combinational read, write on the rising edge while memWrite is high.
  logic [WORD-1:0] mem [DEPTH];
  logic [WORD-1:0] snap [DEPTH];
  logic            tb_fill, tb_we;
  logic [AL-1:0]   tb_addr;
  logic [WORD-1:0] tb_data;

  function automatic logic [WORD-1:0] fill_val(input int k);
    return 16'h5a00 ^ 16'(k);
  endfunction

  assign readData = mem[address];

  always @(posedge clk) begin
    if (tb_fill) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= fill_val(k);
    end else if (memWrite === 1'b1) begin
      mem[address] <= writeData;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct { logic [AL-1:0] a; logic [WORD-1:0] d; } wr_t;
  typedef struct { int words; int cyc; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int start_edge = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [WORD-1:0] d);
    wr_t e;
    e.a = AL'(a);
    e.d = d;
    wq.push_back(e);
  endtask

  task automatic push_dn(input int w, input int c);
    dn_t e;
    e.words = w;
    e.cyc   = c;
    dq.push_back(e);
  endtask

  // Monitor: one line per observed transaction.
  always @(negedge clk) begin
    if (memWrite === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_write_addr", 32'(address), 32'hffff_ffff);
      end else begin
        wr_t e;
        e = wq.pop_front();
        $display("write mem[%0d] = 0x%0h (expect mem[%0d] = 0x%0h)", address, writeData, e.a, e.d);
        chk("write_addr", 32'(address), 32'(e.a));
        chk("write_data", 32'(writeData), 32'(e.d));
      end
    end
    if (done === 1'b1) begin
      int cyc;
      cyc = edge_cnt - start_edge + 1;
      if (dq.size() == 0) begin
        chk("unexpected_done_cycle", 32'(cyc), 32'hffff_ffff);
      end else begin
        dn_t e;
        e = dq.pop_front();
        $display("done cycle %0d wordsDone %0d (expect cycle %0d wordsDone %0d)", cyc, wordsDone, e.cyc, e.words);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("done_words", 32'(wordsDone), 32'(e.words));
        chk("done_busy_low", 32'(busy), 32'd0);
      end
    end
  end

  task automatic poke(input int a, input logic [WORD-1:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = AL'(a); tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic do_start(input int s, input int d, input int c);
    @(negedge clk);
    srcAddr = AL'(s); dstAddr = AL'(d); count = (AL+1)'(c); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_edge = edge_cnt;
  endtask

  task automatic wait_done(input int lim, input string name);
    int n;
    for (n = 0; n < lim && done !== 1'b1; n++) @(negedge clk);
    if (done !== 1'b1) chk({name, "_timeout"}, 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_memRead"}, 32'(memRead), 32'd0);
    chk({tag, "_memWrite"}, 32'(memWrite), 32'd0);
    chk({tag, "_address"}, 32'(address), 32'd0);
    chk({tag, "_writeData"}, 32'(writeData), 32'd0);
    chk({tag, "_wordsDone"}, 32'(wordsDone), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; start = 1'b0; abort = 1'b0;
    srcAddr = '0; dstAddr = '0; count = '0;
    tb_fill = 1'b1; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    tb_fill = 1'b0;
    rstN = 1'b1;
    @(negedge clk);

    // 1: basic three-word copy, busy window and done latency
    poke(100, 16'd5); poke(101, 16'd6); poke(102, 16'd7);
    push_wr(200, 16'd5); push_wr(201, 16'd6); push_wr(202, 16'd7);
    push_dn(3, 7);
    do_start(100, 200, 3);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("t1_busy_cycle%0d", k), 32'(busy), (k <= 6) ? 32'd1 : 32'd0);
    end
    wait_done(20, "t1");
    chk("t1_mem200", 32'(mem[200]), 32'd5);
    chk("t1_mem202", 32'(mem[202]), 32'd7);
    chk("t1_wordsDone_held", 32'(wordsDone), 32'd3);

    // 2: zero-length copy
    push_dn(0, 1);
    do_start(50, 60, 0);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        seen = seen | memRead | memWrite;
      end
      chk("t2_no_mem_access", 32'(seen), 32'd0);
    end

    // 3: wrap around the top of memory with overlapping destination
    poke(1022, 16'hAAAA); poke(1023, 16'hBBBB); poke(0, 16'hCCCC); poke(1, 16'hDDDD);
    push_wr(0, 16'hAAAA); push_wr(1, 16'hBBBB); push_wr(2, 16'hAAAA); push_wr(3, 16'hBBBB);
    push_dn(4, 9);
    do_start(1022, 0, 4);
    wait_done(30, "t3");
    chk("t3_mem0", 32'(mem[0]), 32'hAAAA);
    chk("t3_mem1", 32'(mem[1]), 32'hBBBB);
    chk("t3_mem2", 32'(mem[2]), 32'hAAAA);
    chk("t3_mem3", 32'(mem[3]), 32'hBBBB);

    // 4a: abort during the third READ
    push_wr(700, fill_val(600)); push_wr(701, fill_val(601));
    push_dn(2, 6);
    do_start(600, 700, 10);
    begin
      logic hit;
      hit = 1'b0;
      for (int n = 0; n < 40 && !hit; n++) begin
        @(negedge clk);
        if (memRead === 1'b1 && address == 10'd602) begin hit = 1'b1; abort = 1'b1; end
      end
      chk("t4_abort_read_seen", 32'(hit), 32'd1);
      @(negedge clk);
      abort = 1'b0;
    end
    wait_done(10, "t4a");
    chk("t4_mem702_unchanged", 32'(mem[702]), 32'(fill_val(702)));

    // 4b: abort during the third WRITE
    push_wr(800, fill_val(600)); push_wr(801, fill_val(601)); push_wr(802, fill_val(602));
    push_dn(3, 7);
    do_start(600, 800, 10);
    begin
      logic hit;
      hit = 1'b0;
      for (int n = 0; n < 40 && !hit; n++) begin
        @(negedge clk);
        if (memWrite === 1'b1 && address == 10'd802) begin hit = 1'b1; abort = 1'b1; end
      end
      chk("t4_abort_write_seen", 32'(hit), 32'd1);
      @(negedge clk);
      abort = 1'b0;
    end
    wait_done(10, "t4b");
    chk("t4_mem802", 32'(mem[802]), 32'(fill_val(602)));
    chk("t4_mem803_unchanged", 32'(mem[803]), 32'(fill_val(803)));

    // 5: reset during the WRITE of word 1, then a copy with stray start pulses
    poke(300, 16'd11); poke(301, 16'd12); poke(302, 16'd13); poke(303, 16'd14);
    push_wr(400, 16'd11); push_wr(401, 16'd12);
    do_start(300, 400, 4);
    begin
      logic hit;
      hit = 1'b0;
      for (int n = 0; n < 40 && !hit; n++) begin
        @(negedge clk);
        if (memWrite === 1'b1 && address == 10'd401) hit = 1'b1;
      end
      chk("t5_write1_seen", 32'(hit), 32'd1);
    end
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    check_zero_outputs("t5_midreset");
    repeat (3) @(negedge clk);
    chk("t5_idle_after_reset", 32'(busy), 32'd0);
    chk("t5_mem401", 32'(mem[401]), 32'd12);
    chk("t5_mem402_unchanged", 32'(mem[402]), 32'(fill_val(402)));
    push_wr(500, 16'd11); push_wr(501, 16'd12);
    push_dn(2, 5);
    do_start(300, 500, 2);
    @(negedge clk);
    srcAddr = 10'd900; dstAddr = 10'd950; count = 11'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, "t5");
    chk("t5_mem501", 32'(mem[501]), 32'd12);
    chk("t5_mem950_unchanged", 32'(mem[950]), 32'(fill_val(950)));

    // 6: full-memory self copy
    for (int k = 0; k < DEPTH; k++) begin
      snap[k] = mem[k];
      push_wr(k, mem[k]);
    end
    push_dn(1024, 2049);
    do_start(0, 0, 1024);
    wait_done(2100, "t6");
    begin
      int diffs;
      diffs = 0;
      for (int k = 0; k < DEPTH; k++) if (mem[k] !== snap[k]) diffs++;
      chk("t6_memory_unchanged_diffs", 32'(diffs), 32'd0);
    end

    repeat (4) @(negedge clk);
    chk("leftover_writes", 32'(wq.size()), 32'd0);
    chk("leftover_dones", 32'(dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
